// File: rtl/video_core_csr.sv
// Avalon-MM CSR block: shadow registers committed to active controls at frame start or immediately on IMM.
// Latency: reads return exactly one cycle after the strobe. Backpressure: none; every transfer is accepted.
module video_core_csr #(
    parameter logic [31:0] PARAM_INIT  = 32'h0,
    parameter logic        BYPASS_INIT = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    input  logic        frame_start,
    output logic        bypass,
    output logic [31:0] param,
    output logic        update_done
);

    typedef struct packed {
        logic        bypass;
        logic [31:0] param;
    } ctrl_t;

    typedef enum logic {IDLE, PENDING} state_t;

    localparam ctrl_t CTRL_INIT = '{bypass: BYPASS_INIT, param: PARAM_INIT};

    state_t      state, state_nxt;
    ctrl_t       shadow, shadow_nxt;
    ctrl_t       active, active_nxt;
    logic        commit;
    logic        wr_ctrl, wr_param, wr_shadow, wr_imm, wr_count, wr_clear;
    logic [15:0] frame_count;
    logic [15:0] wrcnt;
    logic [31:0] rd_dat;

    assign wr_ctrl   = avs_write && (avs_address == 2'd0);
    assign wr_param  = avs_write && (avs_address == 2'd1);
    assign wr_shadow = wr_ctrl || wr_param;
    assign wr_imm    = wr_ctrl && avs_writedata[1];
    assign wr_clear  = avs_write && (avs_address == 2'd3);
    assign wr_count  = avs_write && (avs_address != 2'd3);

    always_comb begin
        shadow_nxt = shadow;
        if (wr_ctrl)
            shadow_nxt.bypass = avs_writedata[0];
        if (wr_param)
            shadow_nxt.param = avs_writedata;
    end

    // A frame commit takes the pre-write shadow; a concurrent write keeps us pending for the next frame.
    always_comb begin
        state_nxt  = state;
        active_nxt = active;
        commit     = 1'b0;
        if (wr_imm) begin
            active_nxt = shadow_nxt;
            commit     = 1'b1;
            state_nxt  = IDLE;
        end else if (state == PENDING && frame_start) begin
            active_nxt = shadow;
            commit     = 1'b1;
            state_nxt  = wr_shadow ? PENDING : IDLE;
        end else if (wr_shadow) begin
            state_nxt  = PENDING;
        end
    end

    always_comb begin
        rd_dat = 32'h0;
        case (avs_address)
            2'd0: rd_dat = {31'h0, shadow.bypass};
            2'd1: rd_dat = shadow.param;
            2'd2: rd_dat = {frame_count, 15'h0, state == PENDING};
            2'd3: rd_dat = {16'h0, wrcnt};
            default: rd_dat = 32'h0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state             <= IDLE;
            shadow            <= CTRL_INIT;
            active            <= CTRL_INIT;
            update_done       <= 1'b0;
            frame_count       <= 16'h0;
            wrcnt             <= 16'h0;
            avs_readdata      <= 32'h0;
            avs_readdatavalid <= 1'b0;
        end else begin
            state             <= state_nxt;
            shadow            <= shadow_nxt;
            active            <= active_nxt;
            update_done       <= commit;
            avs_readdatavalid <= avs_read;
            if (avs_read)
                avs_readdata <= rd_dat;
            if (frame_start)
                frame_count <= frame_count + 16'd1;
            if (wr_clear)
                wrcnt <= 16'h0;
            else if (wr_count && wrcnt != 16'hFFFF)
                wrcnt <= wrcnt + 16'd1;
        end
    end

    assign bypass = active.bypass;
    assign param  = active.param;

endmodule

// File: tb/tb_video_core_csr.sv
// Randomized and directed bench with a rule-level reference model and a queue-based scoreboard.
module tb_video_core_csr;

    localparam logic [31:0] P_INIT = 32'hA5A5_0F0F;
    localparam logic        B_INIT = 1'b1;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        frame_start;
    logic        bypass;
    logic [31:0] param;
    logic        update_done;

    video_core_csr #(.PARAM_INIT(P_INIT), .BYPASS_INIT(B_INIT)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .frame_start(frame_start), .bypass(bypass), .param(param), .update_done(update_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        bypass;
        logic [31:0] param;
        logic        upd;
        logic        rdvld;
        logic        rst_chk;
    } exp_t;

    exp_t        cyc_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;

    // reference model: software-visible state
    logic        m_pend, m_sb, m_ab;
    logic [31:0] m_sp, m_ap;
    int          m_frames, m_wrcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic [1:0] addr, input logic wr,
                         input logic [31:0] wd, input logic rd, input logic fs);
        exp_t        e;
        logic [31:0] rv;
        logic        sw, imm, old_sb;
        logic [31:0] old_sp;
        sys_rst = rst; avs_address = addr; avs_write = wr;
        avs_writedata = wd; avs_read = rd; frame_start = fs;
        e.rst_chk = rst;
        e.upd = 1'b0;
        e.rdvld = 1'b0;
        if (rst) begin
            m_pend = 1'b0; m_sb = B_INIT; m_ab = B_INIT; m_sp = P_INIT; m_ap = P_INIT;
            m_frames = 0; m_wrcnt = 0;
        end else begin
            if (rd) begin
                case (addr)
                    2'd0:    rv = {31'h0, m_sb};
                    2'd1:    rv = m_sp;
                    2'd2:    rv = {m_frames[15:0], 15'h0, m_pend};
                    default: rv = {16'h0, m_wrcnt[15:0]};
                endcase
                rd_q.push_back(rv);
            end
            e.rdvld = rd;
            if (fs) m_frames = (m_frames + 1) % 65536;
            if (wr) m_wrcnt = (addr == 2'd3) ? 0 : ((m_wrcnt < 65535) ? m_wrcnt + 1 : 65535);
            old_sb = m_sb; old_sp = m_sp;
            sw  = wr && (addr == 2'd0 || addr == 2'd1);
            imm = wr && (addr == 2'd0) && wd[1];
            if (wr && addr == 2'd0) m_sb = wd[0];
            if (wr && addr == 2'd1) m_sp = wd;
            if (imm) begin
                m_ab = m_sb; m_ap = m_sp; e.upd = 1'b1; m_pend = 1'b0;
            end else if (m_pend && fs) begin
                m_ab = old_sb; m_ap = old_sp; e.upd = 1'b1; m_pend = sw;
            end else if (sw) begin
                m_pend = 1'b1;
            end
        end
        e.bypass = m_ab;
        e.param  = m_ap;
        cyc_q.push_back(e);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        cycle(1'b0, a, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b0, a, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic frame();
        cycle(1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    // monitor: samples on the falling edge, half a cycle after the DUT updates
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("bypass", {31'h0, bypass}, {31'h0, e.bypass});
                chk("param", param, e.param);
                chk("update_done", {31'h0, update_done}, {31'h0, e.upd});
                chk("readdatavalid", {31'h0, avs_readdatavalid}, {31'h0, e.rdvld});
                if (e.rst_chk) chk("readdata_reset", avs_readdata, 32'h0);
            end
            if (avs_readdatavalid === 1'b1) begin
                if (rd_q.size() == 0) chk("unexpected_read", 32'h1, 32'h0);
                else chk("readdata", avs_readdata, rd_q.pop_front());
            end
        end
    end

    initial begin
        cycle(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) rd(a[1:0]);
        idle();

        wr(2'd1, 32'hDEADBEEF);
        rd(2'd2);
        idle();
        frame();
        rd(2'd2);
        idle();

        wr(2'd0, 32'h3);
        rd(2'd2);
        rd(2'd0);
        idle();

        wr(2'd1, 32'h11);
        cycle(1'b0, 2'd1, 1'b1, 32'h22, 1'b0, 1'b1);
        rd(2'd2);
        frame();
        rd(2'd1);
        idle();

        wr(2'd1, 32'h33);
        cycle(1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        frame();
        rd(2'd2);
        rd(2'd1);
        idle();

        // frame counter wrap and write-counter saturation share the same cycles
        for (int i = 0; i < 65537; i++)
            cycle(1'b0, 2'd1, 1'b1, i, 1'b0, 1'b1);
        rd(2'd2);
        rd(2'd3);
        wr(2'd3, 32'h1234);
        rd(2'd3);
        cycle(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        rd(2'd3);
        idle();

        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_wr, r_rd, r_fs;
            logic [1:0]  r_a;
            logic [31:0] r_d;
            r_rst = ($urandom_range(0, 99) == 0);
            r_a   = 2'($urandom_range(0, 3));
            r_wr  = ($urandom_range(0, 99) < 35);
            r_rd  = ($urandom_range(0, 99) < 40);
            r_fs  = ($urandom_range(0, 99) < 12);
            r_d   = $urandom;
            cycle(r_rst, r_a, r_wr, r_d, r_rd, r_fs);
        end
        idle();
        idle();
        @(negedge sys_clk);
        #1;
        chk("cycle_queue_drained", cyc_q.size(), 32'h0);
        chk("read_queue_drained", rd_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
